stream_packet_arbiter: RTL and testbench
========================================

Name: stream_packet_arbiter

Overview:
Shares one downstream stream port (typically the input of the team's stream upsizer) between N_SRC independent packet sources. Arbitration is packet-level round-robin: once a source is granted, it owns the port until its beat carrying s_last_i is accepted. The output is a registered pipeline stage, and each output beat is tagged with the index of the granted source.

Parameters:
T_DATA_WIDTH, 8, width of one data beat
N_SRC, 4, number of requesting sources (2..16)
ID_WIDTH, $clog2(N_SRC), width of source index

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous, active-high reset (rst_n=1 resets)
s_data_i  in  [T_DATA_WIDTH-1:0] x [N_SRC-1:0]  per-source data
s_last_i  in  N_SRC  per-source end-of-packet flag
s_valid_i  in  N_SRC  per-source valid
s_ready_o  out  N_SRC  per-source ready, at most one bit set
m_data_o  out  T_DATA_WIDTH  registered output data
m_last_o  out  1  registered end-of-packet
m_id_o  out  ID_WIDTH  source index of current output beat
m_valid_o  out  1  registered output valid
m_ready_i  in  1  downstream ready
busy_o  out  1  a packet grant is active (state BUSY)

Behaviour:
- Reset values: m_data_o=0, m_last_o=0, m_id_o=0, m_valid_o=0, busy_o=0. State is IDLE and grant=0. Priority pointer last_grant=N_SRC-1, so source 0 has top priority first. Reset mid-packet drops everything immediately; no partial beat is emitted after release.
- out_ready = !m_valid_o || m_ready_i. The output register loads only when out_ready=1.
- s_ready_o[i] = (state==BUSY) && (grant==i) && out_ready. This is combinational from state, grant, m_valid_o and m_ready_i. All other bits are 0. s_ready_o never depends on s_valid_i.
- FSM IDLE:
  - s_ready_o=0.
  - If any s_valid_i is set, the winner is the first set bit scanning from last_grant+1 upward, modulo N_SRC.
  - On the next edge: grant<=winner, state<=BUSY.
  - This costs exactly one arbitration cycle per packet.
- FSM BUSY: an input handshake is s_valid_i[grant] && s_ready_o[grant]. On a handshake:
  - m_data_o<=s_data_i[grant], m_last_o<=s_last_i[grant], m_id_o<=grant, m_valid_o<=1.
  - If s_last_i[grant]=1: last_grant<=grant, state<=IDLE.
- Output drain: if m_valid_o && m_ready_i and there is no new input handshake that cycle, m_valid_o<=0. Data, last and id hold their values; they are don't-care while m_valid_o=0.
- Latency: input beat to m_valid_o is 1 cycle.
- Throughput: one beat per cycle inside a packet. A packet-to-packet gap costs 1 cycle in IDLE, plus any cycle spent draining.
- Backpressure: while m_valid_o=1 and m_ready_i=0, the output holds stable and s_ready_o=0 (AXI-stream stability rule).
- A granted source deasserting valid mid-packet keeps its grant. The arbiter waits indefinitely; there is no timeout.
- Other sources asserting valid during BUSY are ignored until return to IDLE.
- Single-beat packets (valid and last on the first beat) are legal: BUSY lasts one handshake, then IDLE.
- Wrap-around: with last_grant=N_SRC-1, the scan starts at 0.
- busy_o = (state==BUSY).

Decomposition:
- Package stream_pkg holds:
  - enum arb_state_t {IDLE, BUSY}
  - function clog2_min1 (returns 1 for N_SRC<=2)
  - no data typedefs; widths stay parametric
- Sub-module rr_pick (combinational):
  - inputs: req[N_SRC], last_grant
  - outputs: any, winner[ID_WIDTH]
  - implementation: rotate, priority-encode, un-rotate

Test Plan:
- Reset, then source 2 sends 3 beats A0,A1,A2(last) with m_ready_i=1 → s_ready_o=0100 from cycle 2. Outputs A0..A2 appear with m_id_o=2, m_last_o on A2, busy_o drops after A2.
- All 4 sources hold valid, each with 2-beat packets, m_ready_i=1 → packet order is src0,1,2,3,0. There is one idle cycle between packets and no interleaving of ids within a packet.
- Source 1 packet of 4 beats, m_ready_i toggles 1,0,0,1,1,0,1 → no beat lost or duplicated. m_data_o is stable while valid && !ready, and s_ready_o[1]=0 in those cycles.
- Source 3 single-beat packet (valid=1, last=1), with source 0 requesting simultaneously and last_grant=2 → source 3 wins first. Its beat is out 1 cycle after grant, then source 0 is granted.
- Source 0 granted, drops valid for 5 cycles mid-packet while source 1 is valid → grant stays 0 and s_ready_o[1]=0 throughout. The packet completes, then source 1 is granted.
- Assert rst_n mid-packet with m_valid_o=1 → all outputs are 0 asynchronously. After release, source 0 has priority and the first output is a fresh packet.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream arbitration blocks.
package stream_pkg;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } arb_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester strictly after last_grant, wrapping modulo N_SRC.
module rr_pick
  import stream_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned ID_WIDTH = clog2_min1(N_SRC)
) (
  input  logic [N_SRC-1:0]    req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic                any,
  output logic [ID_WIDTH-1:0] winner
);

  localparam int unsigned CW = ID_WIDTH + 1;

  logic [N_SRC-1:0] rot;
  logic [CW-1:0]    start;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    pick;

  always_comb begin
    rot    = '0;
    idx    = '0;
    pick   = '0;
    winner = '0;
    start  = (last_grant == ID_WIDTH'(N_SRC - 1)) ? '0 : CW'(last_grant) + CW'(1);
    // Rotate so that position 0 is the highest-priority source.
    for (int k = 0; k < int'(N_SRC); k++) begin
      idx = CW'(k) + start;
      if (idx >= CW'(N_SRC)) idx = idx - CW'(N_SRC);
      rot[k] = req[idx[ID_WIDTH-1:0]];
    end
    any = |rot;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      if (rot[k]) pick = CW'(k);
    end
    idx = pick + start;
    if (idx >= CW'(N_SRC)) idx = idx - CW'(N_SRC);
    winner = idx[ID_WIDTH-1:0];
  end

endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one registered stream output among N_SRC sources.
module stream_packet_arbiter
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned N_SRC        = 4,
  parameter int unsigned ID_WIDTH     = $clog2(N_SRC)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_SRC-1:0][T_DATA_WIDTH-1:0]  s_data_i,
  input  logic [N_SRC-1:0]                    s_last_i,
  input  logic [N_SRC-1:0]                    s_valid_i,
  output logic [N_SRC-1:0]                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0]             m_data_o,
  output logic                                m_last_o,
  output logic [ID_WIDTH-1:0]                 m_id_o,
  output logic                                m_valid_o,
  input  logic                                m_ready_i,
  output logic                                busy_o
);

  arb_state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]       grant_q, grant_d;
  logic [ID_WIDTH-1:0]       last_grant_q, last_grant_d;
  logic [T_DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                      m_last_q, m_last_d;
  logic [ID_WIDTH-1:0]       m_id_q, m_id_d;
  logic                      m_valid_q, m_valid_d;

  logic                      out_ready;
  logic                      hs;
  logic                      pick_any;
  logic [ID_WIDTH-1:0]       pick_winner;

  rr_pick #(
    .N_SRC    (N_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req        (s_valid_i),
    .last_grant (last_grant_q),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  assign out_ready = !m_valid_q || m_ready_i;
  assign hs        = (state_q == BUSY) && out_ready && s_valid_i[grant_q];

  // Ready never looks at s_valid_i, so sources may wait on it safely.
  always_comb begin
    s_ready_o = '0;
    if (state_q == BUSY && out_ready) s_ready_o[grant_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (hs && s_last_i[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_id_d    = m_id_q;
    m_valid_d = m_valid_q;
    if (hs) begin
      m_data_d  = s_data_i[grant_q];
      m_last_d  = s_last_i[grant_q];
      m_id_d    = grant_q;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(N_SRC - 1);
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      m_id_q       <= '0;
      m_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      m_id_q       <= m_id_d;
      m_valid_q    <= m_valid_d;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign m_id_o    = m_id_q;
  assign m_valid_o = m_valid_q;
  assign busy_o    = (state_q == BUSY);

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed self-checking bench for stream_packet_arbiter (4 sources, 8-bit data).
module tb_stream_packet_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam bit PAT [7] = '{1, 0, 0, 1, 1, 0, 1};

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [N-1:0][W-1:0] s_data;
  logic [N-1:0]       s_last;
  logic [N-1:0]       s_valid;
  logic [N-1:0]       s_ready;
  logic [W-1:0]       m_data;
  logic               m_last;
  logic [IW-1:0]      m_id;
  logic               m_valid;
  logic               m_ready;
  logic               busy;

  logic [8:0]  src_q [N][$];
  logic [N-1:0] hold;
  logic [10:0] out_log [$];
  logic [10:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_packet_arbiter #(
    .T_DATA_WIDTH (W),
    .N_SRC        (N),
    .ID_WIDTH     (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_id_o    (m_id),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .busy_o    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] ent(input logic [1:0] id, input logic last, input logic [7:0] d);
    return {id, last, d};
  endfunction

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      if (src_q[i].size() != 0 && !hold[i]) begin
        s_valid[i] = 1'b1;
        s_last[i]  = src_q[i][0][8];
        s_data[i]  = src_q[i][0][7:0];
      end else begin
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
        s_data[i]  = '0;
      end
    end
  endtask

  // Handshakes and output acceptances are taken from the settled values before the edge.
  task automatic cycle();
    logic [N-1:0] hs;
    hs = s_valid & s_ready;
    if (m_valid && m_ready) out_log.push_back({m_id, m_last, m_data});
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++) begin
      if (hs[i]) void'(src_q[i].pop_front());
    end
    drive();
    #1;
  endtask

  task automatic push_pkt(input int src, input logic [7:0] base, input int n);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = base + 8'(k);
      src_q[src].push_back({(k == n - 1), d});
    end
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    for (int c = 0; c < budget && out_log.size() < n; c++) cycle();
    check(tag, out_log.size(), n);
  endtask

  task automatic check_log(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      check(tag, (i < out_log.size()) ? 32'(out_log[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    exp_q.delete();
    out_log.delete();
  endtask

  int idle_cnt;
  int stall_cnt;
  logic stalled;
  logic [7:0] held;

  initial begin
    s_data  = '0;
    s_last  = '0;
    s_valid = '0;
    hold    = '0;
    m_ready = 1'b1;
    drive();
    repeat (2) cycle();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_id", m_id, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    rst_n = 1'b0;
    cycle();

    // Source 2, three beats, downstream always ready.
    push_pkt(2, 8'hA0, 3);
    drive();
    #1;
    check("s1_idle_busy", busy, 0);
    check("s1_idle_ready", s_ready, 0);
    cycle();
    check("s1_grant_ready", s_ready, 4'b0100);
    check("s1_grant_busy", busy, 1);
    check("s1_grant_mvalid", m_valid, 0);
    cycle();
    check("s1_b0_valid", m_valid, 1);
    check("s1_b0_data", m_data, 8'hA0);
    check("s1_b0_id", m_id, 2);
    check("s1_b0_last", m_last, 0);
    cycle();
    check("s1_b1_data", m_data, 8'hA1);
    cycle();
    check("s1_b2_data", m_data, 8'hA2);
    check("s1_b2_last", m_last, 1);
    check("s1_b2_busy", busy, 0);
    check("s1_b2_ready", s_ready, 0);
    cycle();
    check("s1_drain_valid", m_valid, 0);
    exp_q = '{ent(2, 0, 8'hA0), ent(2, 0, 8'hA1), ent(2, 1, 8'hA2)};
    check_log("s1_log");

    // Fresh reset, all sources competing with 2-beat packets.
    rst_n = 1'b1;
    repeat (2) cycle();
    rst_n = 1'b0;
    cycle();
    out_log.delete();
    push_pkt(0, 8'h00, 2);
    push_pkt(1, 8'h10, 2);
    push_pkt(2, 8'h20, 2);
    push_pkt(3, 8'h30, 2);
    push_pkt(0, 8'h02, 2);
    drive();
    #1;
    idle_cnt = 0;
    for (int t = 0; t < 15; t++) begin
      cycle();
      if (!busy) idle_cnt++;
    end
    check("s2_idle_cycles", idle_cnt, 5);
    wait_log("s2_count", 10, 10);
    exp_q = '{ent(0, 0, 8'h00), ent(0, 1, 8'h01), ent(1, 0, 8'h10), ent(1, 1, 8'h11),
              ent(2, 0, 8'h20), ent(2, 1, 8'h21), ent(3, 0, 8'h30), ent(3, 1, 8'h31),
              ent(0, 0, 8'h02), ent(0, 1, 8'h03)};
    check_log("s2_log");

    // Source 1, four beats under toggling backpressure.
    push_pkt(1, 8'h40, 4);
    drive();
    stall_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      m_ready = PAT[k];
      #1;
      stalled = m_valid && !m_ready;
      held    = m_data;
      if (stalled) begin
        stall_cnt++;
        check("s3_stall_sready", s_ready[1], 0);
      end
      cycle();
      if (stalled) check("s3_stall_hold", m_data, held);
    end
    m_ready = 1'b1;
    check("s3_stalls", stall_cnt, 2);
    wait_log("s3_count", 4, 10);
    exp_q = '{ent(1, 0, 8'h40), ent(1, 0, 8'h41), ent(1, 0, 8'h42), ent(1, 1, 8'h43)};
    check_log("s3_log");

    // Move the pointer to 2, then source 3 and source 0 request together.
    push_pkt(2, 8'h2F, 1);
    drive();
    wait_log("s4_pre", 1, 10);
    out_log.delete();
    push_pkt(3, 8'h3F, 1);
    push_pkt(0, 8'h0F, 1);
    drive();
    #1;
    cycle();
    check("s4_grant3", s_ready, 4'b1000);
    check("s4_busy3", busy, 1);
    cycle();
    check("s4_out3_valid", m_valid, 1);
    check("s4_out3_id", m_id, 3);
    check("s4_out3_data", m_data, 8'h3F);
    check("s4_out3_last", m_last, 1);
    check("s4_idle", busy, 0);
    cycle();
    check("s4_grant0", s_ready, 4'b0001);
    check("s4_busy0", busy, 1);
    cycle();
    check("s4_out0_id", m_id, 0);
    check("s4_out0_data", m_data, 8'h0F);
    cycle();
    out_log.delete();

    // Source 0 stalls mid-packet while source 1 waits.
    push_pkt(0, 8'h50, 3);
    drive();
    #1;
    cycle();
    push_pkt(1, 8'h60, 2);
    drive();
    #1;
    cycle();
    hold[0] = 1'b1;
    drive();
    #1;
    for (int k = 0; k < 5; k++) begin
      check("s5_hold_ready", s_ready, 4'b0001);
      check("s5_hold_busy", busy, 1);
      cycle();
    end
    hold[0] = 1'b0;
    drive();
    #1;
    wait_log("s5_count", 5, 20);
    exp_q = '{ent(0, 0, 8'h50), ent(0, 0, 8'h51), ent(0, 1, 8'h52),
              ent(1, 0, 8'h60), ent(1, 1, 8'h61)};
    check_log("s5_log");

    // Asynchronous reset with a beat sitting on the output.
    push_pkt(2, 8'h70, 3);
    drive();
    #1;
    cycle();
    cycle();
    check("s6_pre_valid", m_valid, 1);
    rst_n = 1'b1;
    #1;
    check("s6_rst_valid", m_valid, 0);
    check("s6_rst_data", m_data, 0);
    check("s6_rst_id", m_id, 0);
    check("s6_rst_last", m_last, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_ready", s_ready, 0);
    for (int i = 0; i < int'(N); i++) src_q[i].delete();
    drive();
    cycle();
    rst_n = 1'b0;
    cycle();
    out_log.delete();
    push_pkt(3, 8'h80, 1);
    push_pkt(0, 8'h90, 1);
    drive();
    #1;
    wait_log("s6_count", 2, 20);
    exp_q = '{ent(0, 1, 8'h90), ent(3, 1, 8'h80)};
    check_log("s6_log");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
